// File: rtl/tilt_decoder.sv
// rtl/tilt_decoder.sv - windowed accelerometer averager with per-axis deadband/hysteresis tilt classifier
module tilt_decoder #(
    parameter int DATA_WIDTH = 12,
    parameter int AVG_LOG2   = 2,
    parameter int DEADBAND   = 64,
    parameter int HYST       = 16,
    parameter int MAG_SHIFT  = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_valid,
    input  logic signed [DATA_WIDTH-1:0] accel_x,
    input  logic signed [DATA_WIDTH-1:0] accel_y,
    output logic                         x_increment,
    output logic                         x_decrement,
    output logic                         y_increment,
    output logic                         y_decrement,
    output logic [7:0]                   x_threshold,
    output logic [7:0]                   y_threshold,
    output logic                         update
);

    localparam int DW = DATA_WIDTH;
    localparam int SW = DATA_WIDTH + AVG_LOG2;

    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_AVG   = 2'd1;
    localparam logic [1:0] ST_CLASS = 2'd2;

    localparam logic [AVG_LOG2-1:0] LAST_CNT = {AVG_LOG2{1'b1}};
    localparam logic signed [DW:0]  DB_POS   = (DW+1)'(DEADBAND);
    localparam logic signed [DW:0]  DB_NEG   = -DB_POS;
    localparam logic [DW:0]         REL_LVL  = (DW+1)'(DEADBAND - HYST);

    logic [1:0]              state_q, state_d;
    logic [AVG_LOG2-1:0]     count_q, count_d;
    logic signed [SW-1:0]    sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic signed [SW-1:0]    add_x, add_y;
    // Window regs keep the already floored average (top bits of the window sum).
    logic signed [DW-1:0]    win_x_q, win_x_d, win_y_q, win_y_d;
    logic signed [DW:0]      avg_x_q, avg_x_d, avg_y_q, avg_y_d;
    logic [DW:0]             abs_x_q, abs_x_d, abs_y_q, abs_y_d;
    logic                    x_inc_q, x_inc_d, x_dec_q, x_dec_d;
    logic                    y_inc_q, y_inc_d, y_dec_q, y_dec_d;
    logic [7:0]              x_thr_q, x_thr_d, y_thr_q, y_thr_d;
    logic                    update_q, update_d;
    logic                    last;

    // Returns {inc, dec}; crossing the opposite deadband flips direction in one window.
    function automatic logic [1:0] next_dir(input logic inc, input logic dec,
                                            input logic signed [DW:0] avg,
                                            input logic [DW:0] mag);
        if (avg > DB_POS)
            return 2'b10;
        else if (avg < DB_NEG)
            return 2'b01;
        else if (mag < REL_LVL)
            return 2'b00;
        else
            return {inc, dec};
    endfunction

    function automatic logic [7:0] clamp_thr(input logic [DW:0] mag);
        logic [DW:0] t;
        t = mag >> MAG_SHIFT;
        if (|t[DW:8])
            return 8'hFF;
        else if (t[7:0] == 8'd0)
            return 8'd1;
        else
            return t[7:0];
    endfunction

    assign add_x = sum_x_q + SW'(accel_x);
    assign add_y = sum_y_q + SW'(accel_y);
    assign last  = sample_valid && (count_q == LAST_CNT);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        sum_x_d  = sum_x_q;
        sum_y_d  = sum_y_q;
        win_x_d  = win_x_q;
        win_y_d  = win_y_q;
        avg_x_d  = avg_x_q;
        avg_y_d  = avg_y_q;
        abs_x_d  = abs_x_q;
        abs_y_d  = abs_y_q;
        x_inc_d  = x_inc_q;
        x_dec_d  = x_dec_q;
        y_inc_d  = y_inc_q;
        y_dec_d  = y_dec_q;
        x_thr_d  = x_thr_q;
        y_thr_d  = y_thr_q;
        update_d = 1'b0;

        // Accumulation runs independently of the FSM so no sample is dropped.
        if (sample_valid) begin
            count_d = count_q + 1'b1;
            if (last) begin
                sum_x_d = '0;
                sum_y_d = '0;
                win_x_d = add_x[SW-1:AVG_LOG2];
                win_y_d = add_y[SW-1:AVG_LOG2];
            end else begin
                sum_x_d = add_x;
                sum_y_d = add_y;
            end
        end

        case (state_q)
            ST_ACCUM: begin
                if (last)
                    state_d = ST_AVG;
            end
            ST_AVG: begin
                avg_x_d = {win_x_q[DW-1], win_x_q};
                avg_y_d = {win_y_q[DW-1], win_y_q};
                abs_x_d = avg_x_d[DW] ? -avg_x_d : avg_x_d;
                abs_y_d = avg_y_d[DW] ? -avg_y_d : avg_y_d;
                state_d = ST_CLASS;
            end
            ST_CLASS: begin
                {x_inc_d, x_dec_d} = next_dir(x_inc_q, x_dec_q, avg_x_q, abs_x_q);
                {y_inc_d, y_dec_d} = next_dir(y_inc_q, y_dec_q, avg_y_q, abs_y_q);
                x_thr_d  = clamp_thr(abs_x_q);
                y_thr_d  = clamp_thr(abs_y_q);
                update_d = 1'b1;
                // Short windows can complete while still classifying the previous one.
                state_d  = last ? ST_AVG : ST_ACCUM;
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_ACCUM;
            count_q  <= '0;
            sum_x_q  <= '0;
            sum_y_q  <= '0;
            win_x_q  <= '0;
            win_y_q  <= '0;
            avg_x_q  <= '0;
            avg_y_q  <= '0;
            abs_x_q  <= '0;
            abs_y_q  <= '0;
            x_inc_q  <= 1'b0;
            x_dec_q  <= 1'b0;
            y_inc_q  <= 1'b0;
            y_dec_q  <= 1'b0;
            x_thr_q  <= 8'd1;
            y_thr_q  <= 8'd1;
            update_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            sum_x_q  <= sum_x_d;
            sum_y_q  <= sum_y_d;
            win_x_q  <= win_x_d;
            win_y_q  <= win_y_d;
            avg_x_q  <= avg_x_d;
            avg_y_q  <= avg_y_d;
            abs_x_q  <= abs_x_d;
            abs_y_q  <= abs_y_d;
            x_inc_q  <= x_inc_d;
            x_dec_q  <= x_dec_d;
            y_inc_q  <= y_inc_d;
            y_dec_q  <= y_dec_d;
            x_thr_q  <= x_thr_d;
            y_thr_q  <= y_thr_d;
            update_q <= update_d;
        end
    end

    assign x_increment = x_inc_q;
    assign x_decrement = x_dec_q;
    assign y_increment = y_inc_q;
    assign y_decrement = y_dec_q;
    assign x_threshold = x_thr_q;
    assign y_threshold = y_thr_q;
    assign update      = update_q;

endmodule
